// File: rtl/sparc_rf_pkg.sv
// Shared sizing and word/address types for the SPARC integer register file.
package sparc_rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DEPTH  = 32;
  localparam int G0_ADDR   = 0;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_word_t;

endpackage

// File: rtl/regfile_entry_32.sv
// One register-file storage word: active-low load enable, async active-high clear.
module regfile_entry_32
  import sparc_rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              i_load_n,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr)
      r_q <= '0;
    else if (!i_load_n)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_2r1w_rdport.sv
// 32x32 SPARC integer register file: one write port, two registered read ports
// sharing a request/valid handshake, with write-to-read bypass and %g0 tied to zero.
module regfile_2r1w_rdport
  import sparc_rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = RF_DEPTH
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              loadE,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              RdReq,
  input  logic [ADDR_W-1:0] RdAddrA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic              RdValid,
  output logic [DATA_W-1:0] DataA,
  output logic [DATA_W-1:0] DataB
);

  localparam logic [ADDR_W-1:0] G0 = ADDR_W'(G0_ADDR);

  logic [DATA_W-1:0] w_q [DEPTH];
  logic              w_wr_act;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  logic              r_valid;
  logic [DATA_W-1:0] r_data_a;
  logic [DATA_W-1:0] r_data_b;

  assign w_wr_act = !loadE;
  assign w_q[0]   = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_entry
    logic w_load_n;
    assign w_load_n = !(w_wr_act && (WrAddr == ADDR_W'(i)));

    regfile_entry_32 #(.DATA_W(DATA_W)) u_entry (
      .Clk      (Clk),
      .Clr      (Clr),
      .i_load_n (w_load_n),
      .i_d      (WrData),
      .o_q      (w_q[i])
    );
  end

  // Bypass gives write-before-read: a same-cycle write wins over the stored word.
  always_comb begin
    w_rd_a = w_q[RdAddrA];
    if (RdAddrA == G0)
      w_rd_a = '0;
    else if (w_wr_act && (WrAddr == RdAddrA))
      w_rd_a = WrData;
  end

  always_comb begin
    w_rd_b = w_q[RdAddrB];
    if (RdAddrB == G0)
      w_rd_b = '0;
    else if (w_wr_act && (WrAddr == RdAddrB))
      w_rd_b = WrData;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_valid  <= 1'b0;
      r_data_a <= '0;
      r_data_b <= '0;
    end else begin
      r_valid <= RdReq;
      if (RdReq) begin
        r_data_a <= w_rd_a;
        r_data_b <= w_rd_b;
      end
    end
  end

  assign RdValid = r_valid;
  assign DataA   = r_data_a;
  assign DataB   = r_data_b;

endmodule
